// File: rtl/lsu_mem_stage_pkg.sv
// Shared load/store definitions: opcodes, FSM encoding, access size and bus command payload.
package lsu_mem_stage_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned BE_W  = 4;
  localparam int unsigned CNT_W = 8;

  localparam logic [OP_W-1:0] OP_LB  = 6'b100000;
  localparam logic [OP_W-1:0] OP_LH  = 6'b100001;
  localparam logic [OP_W-1:0] OP_LW  = 6'b100011;
  localparam logic [OP_W-1:0] OP_LBU = 6'b100100;
  localparam logic [OP_W-1:0] OP_LHU = 6'b100101;
  localparam logic [OP_W-1:0] OP_SB  = 6'b101000;
  localparam logic [OP_W-1:0] OP_SH  = 6'b101001;
  localparam logic [OP_W-1:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } mem_cmd_t;

  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_store(input logic [OP_W-1:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_signed_load(input logic [OP_W-1:0] op);
    return op inside {OP_LB, OP_LH};
  endfunction

  function automatic size_e op_size(input logic [OP_W-1:0] op);
    size_e sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
      default:              sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Data-memory request/acknowledge bus between the LSU (master) and memory (slave).
interface lsu_mem_stage_if;
  import lsu_mem_stage_pkg::*;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [BE_W-1:0] mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables / replicated write data / alignment check on the
// request side, lane select and sign/zero extension on the load return side.
module lsu_align
  import lsu_mem_stage_pkg::*;
(
  input  logic [OP_W-1:0] st_op_i,
  input  logic [1:0]      st_off_i,
  input  logic [XLEN-1:0] st_data_i,
  output logic [BE_W-1:0] st_be_c_o,
  output logic [XLEN-1:0] st_wdata_c_o,
  output logic            st_misaligned_c_o,
  input  logic [OP_W-1:0] ld_op_i,
  input  logic [1:0]      ld_off_i,
  input  logic [XLEN-1:0] ld_rdata_i,
  output logic [XLEN-1:0] ld_data_c_o
);

  size_e       st_sz;
  size_e       ld_sz;
  logic        ld_sgn;
  logic [15:0] ld_lane;

  assign st_sz  = op_size(st_op_i);
  assign ld_sz  = op_size(ld_op_i);
  assign ld_sgn = is_signed_load(ld_op_i);

  // Request side: enables and write data follow the access size and low address bits.
  always_comb begin
    st_be_c_o         = 4'b1111;
    st_wdata_c_o      = st_data_i;
    st_misaligned_c_o = 1'b0;
    case (st_sz)
      SZ_BYTE: begin
        st_be_c_o    = 4'b0001 << st_off_i;
        st_wdata_c_o = {4{st_data_i[7:0]}};
      end
      SZ_HALF: begin
        st_be_c_o         = st_off_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_c_o      = {2{st_data_i[15:0]}};
        st_misaligned_c_o = st_off_i[0];
      end
      default: begin
        st_misaligned_c_o = |st_off_i;
      end
    endcase
  end

  // Shifting by the byte offset lands the addressed byte/halfword at bit 0.
  assign ld_lane = 16'(ld_rdata_i >> {ld_off_i, 3'b000});

  always_comb begin
    ld_data_c_o = ld_rdata_i;
    case (ld_sz)
      SZ_BYTE: ld_data_c_o = {{24{ld_sgn & ld_lane[7]}}, ld_lane[7:0]};
      SZ_HALF: ld_data_c_o = {{16{ld_sgn & ld_lane[15]}}, ld_lane[15:0]};
      default: ld_data_c_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory stage: accepts a load/store from execute, runs one memory bus transaction with a
// timeout, and returns extended load data while stalling the core.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [OP_W-1:0] op_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] store_data_i,
  output logic            stall_c_o,
  output logic            done_o,
  output logic [XLEN-1:0] load_data_o,
  output logic            addr_err_o,
  output logic            bus_err_o,
  lsu_mem_stage_if.master mem
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_cmd_t        cmd_q, cmd_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [1:0]      off_q, off_d;
  logic            req_q, req_d;
  logic            done_q, done_d;
  logic            aerr_q, aerr_d;
  logic            berr_q, berr_d;
  logic [XLEN-1:0] ld_q, ld_d;
  logic            stall_c;
  logic            accept_c;

  logic [BE_W-1:0] st_be;
  logic [XLEN-1:0] st_wdata;
  logic            st_mis;
  logic [XLEN-1:0] ld_data;

  lsu_align u_align (
    .st_op_i           (op_i),
    .st_off_i          (alu_result_i[1:0]),
    .st_data_i         (store_data_i),
    .st_be_c_o         (st_be),
    .st_wdata_c_o      (st_wdata),
    .st_misaligned_c_o (st_mis),
    .ld_op_i           (op_q),
    .ld_off_i          (off_q),
    .ld_rdata_i        (mem.mem_rdata),
    .ld_data_c_o       (ld_data)
  );

  // A timed-out instruction is still presented in the cycle after bus_err; it must retire
  // rather than be re-issued.
  assign accept_c = valid_i && is_mem_op(op_i) && !berr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    op_d    = op_q;
    off_d   = off_q;
    req_d   = 1'b0;
    done_d  = 1'b0;
    aerr_d  = 1'b0;
    berr_d  = 1'b0;
    ld_d    = ld_q;
    stall_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (st_mis) begin
            aerr_d = 1'b1;
            done_d = 1'b1;
          end else begin
            stall_c    = 1'b1;
            req_d      = 1'b1;
            cnt_d      = '0;
            op_d       = op_i;
            off_d      = alu_result_i[1:0];
            cmd_d.we    = is_store(op_i);
            cmd_d.addr  = {alu_result_i[XLEN-1:2], 2'b00};
            cmd_d.be    = st_be;
            cmd_d.wdata = st_wdata;
            state_d    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        // Ack has priority over a timeout in the same cycle.
        if (mem.mem_ack) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_DONE;
          if (!cmd_q.we) begin
            ld_d = ld_data;
          end
        end else if (cnt_q == CNT_LAST) begin
          berr_d  = 1'b1;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          req_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      op_q    <= '0;
      off_q   <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      aerr_q  <= 1'b0;
      berr_q  <= 1'b0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      op_q    <= op_d;
      off_q   <= off_d;
      req_q   <= req_d;
      done_q  <= done_d;
      aerr_q  <= aerr_d;
      berr_q  <= berr_d;
      ld_q    <= ld_d;
    end
  end

  // Stall is combinational from valid; force it low while reset is asserted.
  assign stall_c_o   = stall_c & rst_n;
  assign done_o      = done_q;
  assign load_data_o = ld_q;
  assign addr_err_o  = aerr_q;
  assign bus_err_o   = berr_q;

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = cmd_q.we;
  assign mem.mem_addr  = cmd_q.addr;
  assign mem.mem_be    = cmd_q.be;
  assign mem.mem_wdata = cmd_q.wdata;

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit directly downstream of the execute-stage ALU.
- Consumes the ALU's effective address (alu_result), the opcode and the store operand.
- Runs a request/acknowledge transaction to data memory and returns aligned, extended load data to writeback.
- Stalls the single-cycle core while a memory access is outstanding and flags misaligned or timed-out accesses.

Parameters:
- TIMEOUT, 255: max cycles in WAIT without mem_ack before bus error; 8-bit counter, legal range 1..255.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid  in  1  current instruction is live this cycle
- op  in  6  instruction opcode (bits 31:26)
- alu_result  in  32  effective address from ALU
- store_data  in  32  rt register value for stores
- stall  out  1  hold PC/pipeline this cycle
- done  out  1  one-cycle pulse: access complete (or error)
- load_data  out  32  extended load result for writeback
- addr_err  out  1  one-cycle pulse: misaligned access, no bus cycle issued
- bus_err  out  1  one-cycle pulse: TIMEOUT expired
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_be  out  4  byte enables, little-endian lanes
- mem_wdata  out  32  store data replicated into lanes
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  memory completion

Behaviour:
- Memory ops: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011. All other opcodes are ignored: stall=0, no pulses.
- Reset values: all outputs 0; state IDLE; timeout counter 0. Reset mid-transaction drops mem_req immediately (async). The memory side must tolerate an abandoned request.
- FSM states: IDLE, WAIT, DONE.
- IDLE, valid & mem op:
  - Alignment rules: halfword ops need addr[0]=0; word ops need addr[1:0]=00.
  - Misaligned: addr_err=1 and done=1 next cycle (registered), no mem_req, stall=0, stay IDLE.
  - Aligned: latch op, addr[1:0], mem_addr, mem_be, mem_wdata, mem_we; next state WAIT; stall=1 combinationally this cycle.
- Byte enables: byte -> 4'b0001<<addr[1:0]; half -> addr[1]?1100:0011; word -> 1111.
- mem_wdata: sb = {4{sd[7:0]}}; sh = {2{sd[15:0]}}; sw = sd.
- WAIT: mem_req=1, stall=1, counter increments each cycle.
  - mem_ack: register load_data, next state DONE.
  - Load extraction: select lane by latched addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
  - Stores leave load_data unchanged.
  - Counter reaches TIMEOUT without ack: drop mem_req, bus_err=1, done=1, return to IDLE; load_data unchanged.
  - mem_ack in the same cycle the counter hits TIMEOUT: ack wins, no bus_err.
- DONE: done=1, stall=0 so the core retires the instruction; mem_req=0; next state IDLE. A back-to-back memory op on valid in DONE is not accepted until IDLE next cycle; the core is holding the PC, so valid persists.
- Minimum latency, aligned access: request cycle -> 1st WAIT cycle -> ack in that cycle -> DONE. That is stall for 2 cycles, done on cycle 3.
- valid/op/alu_result changes while in WAIT/DONE are ignored; latched copies are used.
- mem_ack outside WAIT is ignored.
- load_data holds the last completed load value indefinitely.

Decomposition:
- Shared package (cpu_defs):
  - Opcode localparams (OP_LB…OP_SW) shared with ALU/decoder.
  - FSM state encoding: 2-bit, IDLE=0, WAIT=1, DONE=2.
  - Size enum: BYTE/HALF/WORD.
- One sub-module, lsu_align: combinational.
  - Store path: op + addr[1:0] + store_data -> mem_be, mem_wdata, misaligned.
  - Load path: latched op + addr[1:0] + mem_rdata -> extended load_data.
- Top module holds the FSM, latches and timeout counter.

Test Plan:
- lw addr 0x0000_1004, memory acks 3 cycles later with 0xDEADBEEF -> mem_be=1111, mem_addr=0x1004, stall high 4 cycles, done pulse, load_data=0xDEADBEEF.
- lb addr 0x2003, rdata 0x80FF_1234 -> mem_be=0001<<3=1000, load_data=0xFFFF_FF80; lbu same -> 0x0000_0080.
- sh addr 0x3002, store_data 0x1234_ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCD_ABCD; load_data unchanged.
- lw addr 0x1002 -> addr_err pulse, done pulse, mem_req never asserted, stall=0; sh 0x1001 likewise.
- TIMEOUT=4, sw with no ack -> mem_req 4 cycles, then bus_err+done pulse, mem_req=0, IDLE.
- Assert rst_n low during WAIT -> mem_req, stall, done drop immediately; after release, valid addu (op 000000) -> no stall, no pulses.
